// File: rtl/serial_deserializer_pkg.sv
// serial_deserializer_pkg: shared defaults and counter sizing for the deserializer
package serial_deserializer_pkg;
    localparam int DEF_WIDTH = 8;
    localparam bit DEF_MSB_FIRST = 1'b1;
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction
endpackage

// File: rtl/serial_deserializer_word_hold.sv
// serial_deserializer_word_hold: one-word valid/ready holding register with sticky overrun
module serial_deserializer_word_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             overrun
);
    // a completed word lands only if the slot is empty or being drained this edge; otherwise it is dropped and flagged
    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load && (!valid || ready)) data <= word;
            valid   <= load ? 1'b1 : (valid && ready) ? 1'b0 : valid;
            overrun <= (load && valid && !ready) ? 1'b1 : overrun_clr ? 1'b0 : overrun;
        end
    end
endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: assembles a serial bit stream into WIDTH-bit words on a valid/ready interface
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             d_en,
    input  logic             realign,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    input  logic             overrun_clr
);
    localparam int CW = cnt_w(WIDTH);
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt;
    logic             complete;
    assign word     = MSB_FIRST ? {sr[WIDTH-2:0], d} : {d, sr[WIDTH-1:1]};
    assign complete = d_en && !realign && (cnt == CW'(WIDTH - 1));
    // collector: shift in enabled bits, wrap the count on the last bit of a word, realign restarts framing
    always_ff @(posedge clk) begin
        if (rst || realign) begin
            sr  <= '0;
            cnt <= '0;
        end else if (d_en) begin
            sr  <= word;
            cnt <= complete ? '0 : cnt + 1'b1;
        end
    end
    serial_deserializer_word_hold #(.WIDTH(WIDTH)) u_hold (
        .clk         (clk),
        .rst         (rst),
        .load        (complete),
        .word        (word),
        .ready       (ready),
        .overrun_clr (overrun_clr),
        .data        (data),
        .valid       (valid),
        .overrun     (overrun)
    );
endmodule

// File: tb/tb_serial_deserializer.sv
// tb_serial_deserializer: directed checks of both bit orders behind an upstream flip-flop
module tb_serial_deserializer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       src_d = 1'b0;
    logic       src_en = 1'b0;
    logic       d_q = 1'b0;
    logic       en_q = 1'b0;
    logic       realign = 1'b0;
    logic       ready = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [7:0] data_m, data_l;
    logic       valid_m, valid_l, overrun_m, overrun_l;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    // upstream flip-flop stage feeding the deserializer
    always_ff @(posedge clk) begin
        d_q  <= src_d;
        en_q <= src_en;
    end

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .d(d_q), .d_en(en_q), .realign(realign),
        .data(data_m), .valid(valid_m), .ready(ready),
        .overrun(overrun_m), .overrun_clr(overrun_clr)
    );

    serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .d(d_q), .d_en(en_q), .realign(realign),
        .data(data_l), .valid(valid_l), .ready(ready),
        .overrun(overrun_l), .overrun_clr(overrun_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        src_d  = b;
        src_en = 1'b1;
        tick();
        src_en = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send(w[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // reset with live bits on the input
        rst = 1'b1; src_d = 1'b1; src_en = 1'b1; ready = 1'b1;
        tick();
        tick();
        check("rst_data", data_m, 8'h00);
        check("rst_valid", valid_m, 1'b0);
        check("rst_overrun", overrun_m, 1'b0);
        src_en = 1'b0;
        tick();
        rst = 1'b0;

        // basic word, both bit orders
        send_word(8'hA5);
        check("basic_pre_valid", valid_m, 1'b0);
        tick();
        check("basic_valid", valid_m, 1'b1);
        check("basic_data_msb", data_m, 8'hA5);
        check("basic_data_lsb", data_l, 8'hA5);
        tick();
        check("basic_drop", valid_m, 1'b0);
        check("basic_hold_data", data_m, 8'hA5);

        // bits 1,1,0,0,0,0,0,0
        send_word(8'hC0);
        tick();
        check("order_msb", data_m, 8'hC0);
        check("order_lsb", data_l, 8'h03);
        check("order_lsb_valid", valid_l, 1'b1);
        tick();

        // gapped enables
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            send(i[0] ? 1'b0 : 1'b1);
            tick();
        end
        check("gap_valid", valid_m, 1'b1);
        check("gap_data", data_m, 8'h55);
        tick();
        check("gap_drop", valid_m, 1'b0);

        // overrun with stalled consumer
        do_reset();
        ready = 1'b0;
        send_word(8'h11);
        tick();
        check("ovr_first_valid", valid_m, 1'b1);
        check("ovr_first_data", data_m, 8'h11);
        send_word(8'h22);
        check("ovr_pre", overrun_m, 1'b0);
        tick();
        check("ovr_set", overrun_m, 1'b1);
        check("ovr_data_held", data_m, 8'h11);
        check("ovr_valid_held", valid_m, 1'b1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr", overrun_m, 1'b0);
        send_word(8'h22);
        ready = 1'b1;
        tick();
        check("acc_data", data_m, 8'h22);
        check("acc_valid", valid_m, 1'b1);
        check("acc_overrun", overrun_m, 1'b0);
        tick();
        check("acc_drop", valid_m, 1'b0);

        // realign discards a partial word and the bit presented with it
        do_reset();
        for (int i = 0; i < 4; i++) send(1'b1);
        src_d = 1'b1; src_en = 1'b1;
        tick();
        src_en = 1'b0;
        realign = 1'b1;
        tick();
        realign = 1'b0;
        send_word(8'hC3);
        check("realign_no_spurious", valid_m, 1'b0);
        tick();
        check("realign_valid", valid_m, 1'b1);
        check("realign_data", data_m, 8'hC3);
        tick();

        // reset mid-word loses the partial word
        for (int i = 0; i < 4; i++) send(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0);
        tick();
        check("midrst_valid", valid_m, 1'b0);
        check("midrst_data", data_m, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
